// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pacman monster movement engine.
package pacman_pkg;

  typedef enum logic [1:0] {
    ModeScatter = 2'd0,
    ModeChase   = 2'd1,
    ModeFright  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } sweep_e;

  localparam int unsigned DefMaxX = 319;
  localparam int unsigned DefMaxY = 239;

  // Bit 0 selects the right edge, bit 1 the bottom edge.
  function automatic logic [1:0] scatter_corner(input int unsigned idx);
    return {idx[1], idx[0]};
  endfunction

endpackage

// File: rtl/monster_step.sv
// Combinational single-pixel step: seek (tx, ty) or flee from it, clamped to the playfield.
module monster_step #(
  parameter int unsigned W     = 9,
  parameter int unsigned MAX_X = 319,
  parameter int unsigned MAX_Y = 239
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] tx,
  input  logic [W-1:0] ty,
  input  logic         flee,
  output logic [W-1:0] nx,
  output logic [W-1:0] ny
);

  localparam logic [W-1:0] MaxX = W'(MAX_X);
  localparam logic [W-1:0] MaxY = W'(MAX_Y);
  localparam logic [W-1:0] One  = W'(1);

  always_comb begin
    nx = x;
    ny = y;
    if (flee) begin
      if (x <= tx && x != '0) begin
        nx = x - One;
      end else if (x > tx && x < MaxX) begin
        nx = x + One;
      end else if (y <= ty && y != '0) begin
        ny = y - One;
      end else if (y > ty && y < MaxY) begin
        ny = y + One;
      end
    end else if (x != tx) begin
      if (x < tx) begin
        if (x < MaxX) nx = x + One;
      end else if (x != '0) begin
        nx = x - One;
      end
    end else if (y != ty) begin
      if (y < ty) begin
        if (y < MaxY) ny = y + One;
      end else if (y != '0) begin
        ny = y - One;
      end
    end
  end

endmodule

// File: rtl/monster_chaser.sv
// Multi-monster movement engine: tick divider, mode sequencer, per-tick sweep that steps
// one monster per cycle through a shared step unit, and a registered indexed read port.
module monster_chaser
  import pacman_pkg::*;
#(
  parameter int unsigned W              = 9,
  parameter int unsigned N_MON          = 4,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned MAX_X          = DefMaxX,
  parameter int unsigned MAX_Y          = DefMaxY,
  parameter int unsigned HOME_X         = 100,
  parameter int unsigned HOME_Y         = 100,
  parameter int unsigned HOME_DX        = 16,
  parameter int unsigned TICK_DIV       = 8,
  parameter int unsigned SCATTER_SWEEPS = 7,
  parameter int unsigned CHASE_SWEEPS   = 20,
  parameter int unsigned FRIGHT_SWEEPS  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frighten,
  input  logic [W-1:0]     p_x,
  input  logic [W-1:0]     p_y,
  input  logic [IDX_W-1:0] index,
  output logic [W-1:0]     m_x,
  output logic [W-1:0]     m_y,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             sweep_done
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned CntW = 8;

  // Tick divider
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = en && (div_q == DivW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= tick ? '0 : div_q + DivW'(1);
    end
  end

  // Sweep FSM
  sweep_e          state_q, state_d;
  logic [IDX_W-1:0] k_q;
  logic             last_k;
  logic [W-1:0]     px_q, py_q;
  mode_e            lmode_q;

  assign last_k = (k_q == IDX_W'(N_MON - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      lmode_q <= ModeScatter;
    end else begin
      state_q <= state_d;
      k_q     <= (state_q == StSweep) ? k_q + IDX_W'(1) : '0;
      if (state_q == StIdle && tick) begin
        px_q    <= p_x;
        py_q    <= p_y;
        lmode_q <= mode_e'(mode);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StSweep;
      StSweep: if (last_k) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q == StSweep);
    sweep_done = (state_q == StDone);
  end

  // Mode sequencer
  mode_e           mode_q, mode_d, saved_mode_q, saved_mode_d;
  logic [CntW-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, cnt_inc, lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= ModeScatter;
      cnt_q        <= '0;
      saved_mode_q <= ModeScatter;
      saved_cnt_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      saved_mode_q <= saved_mode_d;
      saved_cnt_q  <= saved_cnt_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    saved_mode_d = saved_mode_q;
    saved_cnt_d  = saved_cnt_q;
    cnt_inc      = cnt_q + CntW'(1);
    lim          = (mode_q == ModeScatter) ? CntW'(SCATTER_SWEEPS) :
                   (mode_q == ModeChase)   ? CntW'(CHASE_SWEEPS)   : CntW'(FRIGHT_SWEEPS);
    // frighten takes priority over a coincident sweep_done; that increment is dropped
    if (frighten) begin
      if (mode_q != ModeFright) begin
        saved_mode_d = mode_q;
        saved_cnt_d  = cnt_q;
      end
      mode_d = ModeFright;
      cnt_d  = '0;
    end else if (sweep_done) begin
      if (cnt_inc == lim) begin
        unique case (mode_q)
          ModeScatter: begin
            mode_d = ModeChase;
            cnt_d  = '0;
          end
          ModeChase: begin
            mode_d = ModeScatter;
            cnt_d  = '0;
          end
          default: begin
            mode_d = saved_mode_q;
            cnt_d  = saved_cnt_q;
          end
        endcase
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign mode = mode_q;

  // Position storage, shared step unit, read port
  logic [W-1:0] pos_x_q [N_MON];
  logic [W-1:0] pos_y_q [N_MON];
  logic [W-1:0] cur_x, cur_y, rd_x, rd_y, tgt_x, tgt_y, nx, ny;
  logic [1:0]   corner;

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    rd_x  = '0;
    rd_y  = '0;
    for (int i = 0; i < N_MON; i++) begin
      if (k_q == IDX_W'(i)) begin
        cur_x = pos_x_q[i];
        cur_y = pos_y_q[i];
      end
      if (index == IDX_W'(i)) begin
        rd_x = pos_x_q[i];
        rd_y = pos_y_q[i];
      end
    end
  end

  always_comb begin
    corner = scatter_corner(32'(k_q));
    if (lmode_q == ModeScatter) begin
      tgt_x = corner[0] ? W'(MAX_X) : '0;
      tgt_y = corner[1] ? W'(MAX_Y) : '0;
    end else begin
      tgt_x = px_q;
      tgt_y = py_q;
    end
  end

  monster_step #(
    .W     (W),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_step (
    .x    (cur_x),
    .y    (cur_y),
    .tx   (tgt_x),
    .ty   (tgt_y),
    .flee (lmode_q == ModeFright),
    .nx   (nx),
    .ny   (ny)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MON; i++) begin
        pos_x_q[i] <= W'(HOME_X + i * HOME_DX);
        pos_y_q[i] <= W'(HOME_Y);
      end
    end else if (busy) begin
      for (int i = 0; i < N_MON; i++) begin
        if (k_q == IDX_W'(i)) begin
          pos_x_q[i] <= nx;
          pos_y_q[i] <= ny;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_x <= '0;
      m_y <= '0;
    end else begin
      m_x <= rd_x;
      m_y <= rd_y;
    end
  end

endmodule

// File: tb/tb_monster_chaser.sv
// Scoreboard bench for monster_chaser: a cycle-level behavioural model predicts outputs,
// a monitor compares them one clock edge later.
module tb_monster_chaser;

  localparam int N    = 4;
  localparam int MAXX = 319;
  localparam int MAXY = 239;
  localparam int TDIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       frighten = 1'b0;
  logic [8:0] p_x = '0;
  logic [8:0] p_y = '0;
  logic [2:0] index = 3'd2;
  logic [8:0] m_x, m_y;
  logic [1:0] mode;
  logic       busy, sweep_done;

  always #5 clk = ~clk;

  monster_chaser dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frighten   (frighten),
    .p_x        (p_x),
    .p_y        (p_y),
    .index      (index),
    .m_x        (m_x),
    .m_y        (m_y),
    .mode       (mode),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  typedef struct {
    int mx;
    int my;
    int md;
    int bz;
    int dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int mx[N];
  int my[N];
  int m_mode, m_cnt, sv_mode, sv_cnt, div_cnt, ph, lpx, lpy, lmode, rdx, rdy;

  function automatic int dur(input int m);
    return (m == 0) ? 7 : (m == 1) ? 20 : 6;
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 100 + 16 * i;
      my[i] = 100;
    end
    m_mode = 0; m_cnt = 0; sv_mode = 0; sv_cnt = 0;
    div_cnt = 0; ph = 0; lpx = 0; lpy = 0; lmode = 0; rdx = 0; rdy = 0;
  endfunction

  function automatic void move_one(input int k);
    int tx, ty;
    if (lmode == 0) begin
      tx = (k % 2 == 1) ? MAXX : 0;
      ty = ((k / 2) % 2 == 1) ? MAXY : 0;
    end else begin
      tx = lpx;
      ty = lpy;
    end
    if (lmode == 2) begin
      if (mx[k] <= tx && mx[k] > 0) mx[k]--;
      else if (mx[k] > tx && mx[k] < MAXX) mx[k]++;
      else if (my[k] <= ty && my[k] > 0) my[k]--;
      else if (my[k] > ty && my[k] < MAXY) my[k]++;
    end else if (mx[k] != tx) begin
      mx[k] = clamp(mx[k] + sgn(tx - mx[k]), MAXX);
    end else begin
      my[k] = clamp(my[k] + sgn(ty - my[k]), MAXY);
    end
  endfunction

  // Advance the model across one rising edge with the given inputs, then queue the outputs.
  function automatic void model_edge(input bit r, input bit e, input bit f,
                                     input int px, input int py, input int idx);
    bit   done_now;
    exp_t x;
    if (r) begin
      model_reset();
    end else begin
      done_now = (ph == N + 1);
      rdx = (idx < N) ? mx[idx] : 0;
      rdy = (idx < N) ? my[idx] : 0;
      if (ph >= 1 && ph <= N) move_one(ph - 1);
      if (ph == N + 1) ph = 0;
      else if (ph >= 1) ph++;
      else if (e && div_cnt == TDIV - 1) begin
        ph = 1; lpx = px; lpy = py; lmode = m_mode;
      end
      if (f) begin
        if (m_mode != 2) begin
          sv_mode = m_mode;
          sv_cnt  = m_cnt;
        end
        m_mode = 2;
        m_cnt  = 0;
      end else if (done_now) begin
        m_cnt++;
        if (m_cnt == dur(m_mode)) begin
          if (m_mode == 2) begin
            m_mode = sv_mode;
            m_cnt  = sv_cnt;
          end else begin
            m_mode = 1 - m_mode;
            m_cnt  = 0;
          end
        end
      end
      if (e) div_cnt = (div_cnt + 1) % TDIV;
    end
    x.mx = rdx; x.my = rdy; x.md = m_mode;
    x.bz = (ph >= 1 && ph <= N) ? 1 : 0;
    x.dn = (ph == N + 1) ? 1 : 0;
    exp_q.push_back(x);
  endfunction

  task automatic drive(input bit r, input bit e, input bit f,
                       input int px, input int py, input int idx);
    @(negedge clk);
    rst = r; en = e; frighten = f;
    p_x = 9'(px); p_y = 9'(py); index = 3'(idx);
    model_edge(r, e, f, px, py, idx);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("m_x", int'(m_x), x.mx);
        chk("m_y", int'(m_y), x.my);
        chk("mode", int'(mode), x.md);
        chk("busy", int'(busy), x.bz);
        chk("sweep_done", int'(sweep_done), x.dn);
      end
    end
  end

  // Stimulus
  initial begin
    int px, py, n;
    model_reset();
    repeat (3) drive(1, 0, 0, 0, 0, 2);
    // Directed: scatter sweeps into chase with the player at (100, 50), then fright pulses
    for (int c = 0; c < 8 * 13; c++) drive(0, 1, 0, 100, 50, c % 4);
    drive(0, 1, 1, 100, 50, 0);
    for (int c = 0; c < 8 * 6 + 4; c++) drive(0, 1, 0, 100, 50, c % 5);
    for (int c = 0; c < 8 * 3; c++) drive(0, 1, 0, 10, 5, c % 4);
    drive(0, 1, 1, 10, 5, 0);
    for (int c = 0; c < 8 * 3; c++) drive(0, 1, 0, 10, 5, c % 4);
    drive(0, 1, 1, 10, 5, 1);
    for (int c = 0; c < 8 * 30; c++) drive(0, 1, 0, 10, 5, c % 8);
    // Reset during sweep cycle 2
    n = 0;
    while (ph != 3 && n < 40) begin
      drive(0, 1, 0, 200, 200, 0);
      n++;
    end
    chk("reach_sweep_cycle2", ph, 3);
    drive(1, 1, 0, 200, 200, 3);
    for (int c = 0; c < N + 1; c++) drive(0, 0, 0, 0, 0, c);
    // Randomised traffic
    px = 160; py = 120;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        px = $urandom_range(0, MAXX);
        py = $urandom_range(0, MAXY);
        if ($urandom_range(0, 3) == 0) begin
          px = ($urandom_range(0, 1) == 1) ? MAXX : 0;
          py = ($urandom_range(0, 1) == 1) ? MAXY : 0;
        end
      end
      drive($urandom_range(0, 1499) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 149) == 0, px, py, $urandom_range(0, 7));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
